// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit MIPS-style core.
// Opcode encodings and the signed-add overflow helper.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 3;
  localparam int ADDR_W = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LI  = 2'b01;
  localparam logic [1:0] OP_LDD = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  function automatic logic add_ovf(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] s
  );
    return (a[DATA_W-1] == b[DATA_W-1]) &&
           (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

endpackage

// File: rtl/register_file.sv
// 8x8 signed register file: two operand reads, one debug read,
// one synchronous write, async active-low clear.
module register_file
  import cpu_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REG_AW-1:0]        rs_addr,
  input  logic [REG_AW-1:0]        rd_addr,
  input  logic [REG_AW-1:0]        dbg_addr,
  output logic signed [DATA_W-1:0] rs_data,
  output logic signed [DATA_W-1:0] rd_data,
  output logic signed [DATA_W-1:0] dbg_data,
  input  logic                     we,
  input  logic [REG_AW-1:0]        waddr,
  input  logic signed [DATA_W-1:0] wdata
);

  logic signed [DATA_W-1:0] regs [2**REG_AW];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**REG_AW; i++)
        regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rs_data  = regs[rs_addr];
  assign rd_data  = regs[rd_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/execute_stage.sv
// Execute/writeback stage: ALU, WB forwarding, EX/WB register,
// registered jump redirect and wrong-path flush counter.
module execute_stage
  import cpu_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [1:0]               opc,
  input  logic [REG_AW-1:0]        reg_src,
  input  logic [REG_AW-1:0]        reg_dest,
  input  logic [2:0]               im_da,
  input  logic [ADDR_W-1:0]        pja,
  input  logic signed [DATA_W-1:0] reg_data,
  output logic                     jump_taken,
  output logic [ADDR_W-1:0]        jump_target,
  output logic                     ovf,
  input  logic [REG_AW-1:0]        dbg_addr,
  output logic signed [DATA_W-1:0] dbg_data
);

  logic                     wb_valid;
  logic [REG_AW-1:0]        wb_dest;
  logic signed [DATA_W-1:0] wb_result;
  logic [1:0]               flush_cnt;

  logic signed [DATA_W-1:0] rf_rs, rf_rd;
  logic signed [DATA_W-1:0] rs_val, rd_val;
  logic signed [DATA_W-1:0] sum, result;
  logic                     live, is_jmp, is_add;

  register_file u_rf (
    .clk      (clk),
    .reset    (reset),
    .rs_addr  (reg_src),
    .rd_addr  (reg_dest),
    .dbg_addr (dbg_addr),
    .rs_data  (rf_rs),
    .rd_data  (rf_rd),
    .dbg_data (dbg_data),
    .we       (wb_valid),
    .waddr    (wb_dest),
    .wdata    (wb_result)
  );

  // WB result bypasses the not-yet-written register file
  assign rs_val = (wb_valid && wb_dest == reg_src) ? wb_result : rf_rs;
  assign rd_val = (wb_valid && wb_dest == reg_dest) ? wb_result : rf_rd;

  assign sum    = rd_val + rs_val;
  assign live   = in_valid && (flush_cnt == 2'd0);
  assign is_jmp = live && (opc == OP_JMP);
  assign is_add = live && (opc == OP_ADD);

  always_comb begin
    result = rd_val;
    unique case (opc)
      OP_ADD: result = sum;
      OP_LI:  result = {5'b0, im_da};
      OP_LDD: result = reg_data;
      OP_JMP: result = rd_val;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid    <= 1'b0;
      wb_dest     <= '0;
      wb_result   <= '0;
      jump_taken  <= 1'b0;
      jump_target <= '0;
      ovf         <= 1'b0;
      flush_cnt   <= 2'd0;
    end else begin
      wb_valid   <= live && (opc != OP_JMP);
      wb_dest    <= reg_dest;
      wb_result  <= result;
      jump_taken <= is_jmp;
      if (is_jmp)
        jump_target <= pja;
      if (is_add && add_ovf(rd_val, rs_val, sum))
        ovf <= 1'b1;
      // bubbles leave the squash window untouched
      if (is_jmp)
        flush_cnt <= 2'(FLUSH_DEPTH);
      else if (in_valid && flush_cnt != 2'd0)
        flush_cnt <= flush_cnt - 2'd1;
    end
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute and writeback stage of the 8-bit pipelined MIPS-style core, directly downstream of `pipeline_register`. Consumes the latched opcode, register addresses, immediate, jump address and data byte, performs the operation against an internal 8×8 signed register file, and writes the result back one cycle later. Issues a registered jump redirect to fetch and squashes wrong-path instructions already in flight.

## Interface
- `FLUSH_DEPTH`, 2, number of valid instructions squashed after a taken jump (1..3)
- `clk` input 1 — single clock, all state on rising edge
- `reset` input 1 — asynchronous, active-low (asserted at 0)
- `in_valid` input 1 — EX-stage instruction valid (from upstream stage)
- `opc` input 2 — opcode
- `reg_src` input 3 — source register address
- `reg_dest` input 3 — destination register address
- `im_da` input 3 — unsigned immediate
- `pja` input 8 — jump target address
- `reg_data` input 8 signed — data byte carried from decode
- `jump_taken` output 1 — one-cycle redirect pulse to fetch
- `jump_target` output 8 — redirect address, valid while `jump_taken`=1
- `ovf` output 1 — sticky signed-overflow flag
- `dbg_addr` input 3 / `dbg_data` output 8 signed — combinational register-file read port (post-write value not visible until after the write edge)

## Operation
- Opcodes: 00 ADD rd←rd+rs; 01 LI rd←{5'b0,im_da}; 10 LDD rd←reg_data; 11 JMP to `pja`, no register write.
- ADD is 8-bit two's-complement, wraps modulo 256; signed overflow (operands same sign, result sign differs) sets `ovf`, which stays 1 until reset.
- EX operands read combinationally from the register file; forwarding: if WB holds a valid write to the same address, the WB result replaces the register-file value (applies to rs and rd independently).
- EX/WB register captures {wb_valid, wb_dest, wb_result} each edge; wb_valid=in_valid & not squashed & opc≠11.
- Register file writes wb_result to wb_dest on the edge after EX capture when wb_valid=1.
- Squash: a non-squashed valid JMP loads the flush counter with FLUSH_DEPTH; while counter>0 each valid EX instruction is discarded (no write, no `ovf` update, JMP ignored) and the counter decrements. Invalid cycles do not decrement.
- Reset values: all 8 registers 0, wb_valid 0, wb_dest 0, wb_result 0, `jump_taken` 0, `jump_target` 0, `ovf` 0, flush counter 0. Reset mid-operation discards the in-flight WB write.

## Timing
- Cycle N: valid instruction in EX. Edge ending N: EX/WB captured; `jump_taken`/`jump_target` registered. Cycle N+1: `jump_taken`=1 for exactly one cycle. Edge ending N+1: register file updated.
- Back-to-back dependent instructions need no stall: forwarding covers the only hazard (distance 1); distance ≥2 reads the register file.
- Same-address rs=rd in ADD uses one forwarded value for both.
- Counter reaching 0 at an edge makes the next cycle's instruction live.

## Structure
- Package `cpu_pkg`: opcode constants (OP_ADD, OP_LI, OP_LDD, OP_JMP), DATA_W=8, REG_AW=3, ADDR_W=8.
- Sub-module `register_file`: 8×8 signed, two combinational read ports plus debug port, one synchronous write port, async active-low reset to 0.
- Top holds ALU, forwarding muxes, EX/WB register, jump register, flush counter.

## Test plan
- Reset low mid-run with pending WB write → all `dbg_data` reads 0, `jump_taken`=0, `ovf`=0 after release.
- LI r1,5; LI r2,3; ADD r1,r2 back-to-back → r1=8 two cycles after ADD (forwarding exercised).
- LDD r3,0x7F; LI r4,1; ADD r3,r4 → r3=0x80 (−128), `ovf`=1, stays 1 after further clean ADDs.
- JMP 0x42 at cycle N, then LI r5,7; LI r6,7; LI r7,7 → `jump_taken`=1 only in N+1 with target 0x42; r5=r6=0, r7=7 (FLUSH_DEPTH=2).
- JMP followed by invalid cycle, then JMP 0x10, then LI r1,1 → second JMP squashed, no second pulse; counter not decremented by bubble.
- ADD r2,r2 with r2=0xC0 → r2=0x80, `ovf` unchanged (no overflow).
